// File: rtl/fb_display_unit.sv
// fb_display_unit: 800x600@72 VGA scan-out of the 200x150 12-bit framebuffer, each pixel shown 4x4.
// Define FB_CURSOR_EN to overlay an inverting crosshair at the paint cursor.
module fb_display_unit #(
   parameter int H_VIS  = 800,
   parameter int H_FP   = 56,
   parameter int H_SW   = 120,
   parameter int H_BP   = 64,
   parameter int V_VIS  = 600,
   parameter int V_FP   = 37,
   parameter int V_SW   = 6,
   parameter int V_BP   = 23,
   parameter int FB_W   = 200,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [14:0] cursor,
   output logic [14:0] raddr,
   input  logic [11:0] rdata,
   output logic        hs,
   output logic        vs,
   output logic        de,
   output logic [11:0] rgb
);
   localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
   localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
   localparam logic [10:0] H_VIS_C = 11'(H_VIS);
   localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SW - 1);
   localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
   localparam logic [9:0]  V_VIS_C = 10'(V_VIS);
   localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
   localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SW - 1);
   localparam logic [14:0] ROW_STEP = 15'(FB_W);

   logic [10:0]     hcnt_q, hcnt_d;
   logic [9:0]      vcnt_q, vcnt_d;
   logic [14:0]     row_base_q, row_base_d, raddr_q, raddr_d;
   logic [RD_LAT:0] hs_p_q, hs_p_d, vs_p_q, vs_p_d, de_p_q, de_p_d;
   logic            vis, line_end;

   // row_base tracks (vcnt>>2)*FB_W incrementally so no multiplier is needed
   always_comb begin
      line_end   = hcnt_q == H_LAST;
      vis        = hcnt_q < H_VIS_C && vcnt_q < V_VIS_C;
      hcnt_d     = line_end ? '0 : hcnt_q + 11'd1;
      vcnt_d     = !line_end ? vcnt_q : vcnt_q == V_LAST ? '0 : vcnt_q + 10'd1;
      row_base_d = !line_end ? row_base_q : vcnt_q == V_LAST ? '0 :
                   &vcnt_q[1:0] ? row_base_q + ROW_STEP : row_base_q;
      raddr_d    = vis ? row_base_q + {6'd0, hcnt_q[10:2]} : '0;
      hs_p_d     = {hs_p_q[RD_LAT-1:0], hcnt_q >= HS_BEG && hcnt_q <= HS_END};
      vs_p_d     = {vs_p_q[RD_LAT-1:0], vcnt_q >= VS_BEG && vcnt_q <= VS_END};
      de_p_d     = {de_p_q[RD_LAT-1:0], vis};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         row_base_q <= '0;
         raddr_q    <= '0;
         hs_p_q     <= '0;
         vs_p_q     <= '0;
         de_p_q     <= '0;
      end else begin
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         row_base_q <= row_base_d;
         raddr_q    <= raddr_d;
         hs_p_q     <= hs_p_d;
         vs_p_q     <= vs_p_d;
         de_p_q     <= de_p_d;
      end
   end

   assign raddr = raddr_q;
   assign hs    = hs_p_q[RD_LAT];
   assign vs    = vs_p_q[RD_LAT];
   assign de    = de_p_q[RD_LAT];

`ifdef FB_CURSOR_EN
   localparam int FB_H = 150;
   localparam logic [14:0] ADDR_MAX = 15'(FB_W * FB_H - 1);

   typedef enum logic {DEC_IDLE, DEC_RUN} dec_t;
   dec_t            dec_q, dec_d;
   logic [14:0]     cin_q, cin_d, tgt_q, tgt_d, rem_q, rem_d;
   logic [7:0]      row_q, row_d, dcol_q, dcol_d, drow_q, drow_d;
   logic [7:0]      ccol_q, ccol_d, crow_q, crow_d;
   logic [9:0]      fcol, frow, ccol_x, crow_x;
   logic            on_col, on_row;
   logic [RD_LAT:0] cur_p_q, cur_p_d;

   // Divide-by-subtraction: restarts whenever the registered cursor differs from the one in flight
   always_comb begin
      cin_d  = cursor > ADDR_MAX ? ADDR_MAX : cursor;
      tgt_d  = tgt_q;
      rem_d  = rem_q;
      row_d  = row_q;
      dcol_d = dcol_q;
      drow_d = drow_q;
      dec_d  = dec_q;
      if (cin_q != tgt_q) begin
         tgt_d = cin_q;
         rem_d = cin_q;
         row_d = '0;
         dec_d = DEC_RUN;
      end else if (dec_q == DEC_RUN) begin
         if (rem_q >= ROW_STEP) begin
            rem_d = rem_q - ROW_STEP;
            row_d = row_q + 8'd1;
         end else begin
            dcol_d = rem_q[7:0];
            drow_d = row_q;
            dec_d  = DEC_IDLE;
         end
      end
      ccol_d  = hcnt_d == '0 && vcnt_d == '0 ? dcol_q : ccol_q;
      crow_d  = hcnt_d == '0 && vcnt_d == '0 ? drow_q : crow_q;
      fcol    = {1'b0, hcnt_q[10:2]};
      frow    = {2'b0, vcnt_q[9:2]};
      ccol_x  = {2'b0, ccol_q};
      crow_x  = {2'b0, crow_q};
      on_col  = fcol == ccol_x && frow + 10'd3 >= crow_x && frow <= crow_x + 10'd3;
      on_row  = frow == crow_x && fcol + 10'd3 >= ccol_x && fcol <= ccol_x + 10'd3;
      cur_p_d = {cur_p_q[RD_LAT-1:0], vis && (on_col || on_row)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_q   <= DEC_IDLE;
         cin_q   <= '0;
         tgt_q   <= '0;
         rem_q   <= '0;
         row_q   <= '0;
         dcol_q  <= '0;
         drow_q  <= '0;
         ccol_q  <= '0;
         crow_q  <= '0;
         cur_p_q <= '0;
      end else begin
         dec_q   <= dec_d;
         cin_q   <= cin_d;
         tgt_q   <= tgt_d;
         rem_q   <= rem_d;
         row_q   <= row_d;
         dcol_q  <= dcol_d;
         drow_q  <= drow_d;
         ccol_q  <= ccol_d;
         crow_q  <= crow_d;
         cur_p_q <= cur_p_d;
      end
   end

   assign rgb = de ? (cur_p_q[RD_LAT] ? ~rdata : rdata) : '0;
`else
   logic unused_cursor;
   assign unused_cursor = ^cursor;
   assign rgb = de ? rdata : '0;
`endif
endmodule

// File: tb/tb_fb_display_unit.sv
// tb_fb_display_unit: checks a full-size instance (RD_LAT=1) over the first lines and a
// shrunken-geometry instance (RD_LAT=2) over whole frames against an arithmetic screen model.
module tb_fb_display_unit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

`ifdef FB_CURSOR_EN
   localparam bit CUR_EN = 1'b1;
`else
   localparam bit CUR_EN = 1'b0;
`endif

   logic        rst_a, rst_b, hs_a, vs_a, de_a, hs_b, vs_b, de_b;
   logic [14:0] cur_a, cur_b, ra_a, ra_b;
   logic [11:0] rd_a, rd_b, rd_b1, rgb_a, rgb_b;
   int          n_tests = 0;
   int          n_fail = 0;

   fb_display_unit u_a (
      .clk(clk), .rst(rst_a), .cursor(cur_a), .raddr(ra_a), .rdata(rd_a),
      .hs(hs_a), .vs(vs_a), .de(de_a), .rgb(rgb_a)
   );

   fb_display_unit #(
      .H_VIS(40), .H_FP(4), .H_SW(6), .H_BP(6),
      .V_VIS(24), .V_FP(3), .V_SW(2), .V_BP(3), .RD_LAT(2)
   ) u_b (
      .clk(clk), .rst(rst_b), .cursor(cur_b), .raddr(ra_b), .rdata(rd_b),
      .hs(hs_b), .vs(vs_b), .de(de_b), .rgb(rgb_b)
   );

   // RAM models: data word is the low 12 bits of the address
   always @(posedge clk) begin
      rd_a  <= ra_a[11:0];
      rd_b1 <= ra_b[11:0];
      rd_b  <= rd_b1;
   end

   function automatic int iabs(input int x);
      return x < 0 ? -x : x;
   endfunction

   // Expected pins k clocks after reset release, from screen position arithmetic
   function automatic void model(input bit b, input int k, input int cc, input int cr,
                                 output logic e_hs, output logic e_vs, output logic e_de,
                                 output logic [14:0] e_ra, output logic [11:0] e_rgb);
      int ht, vt, hv, vv, hs0, hs1, vs0, vs1, lat, t, h, v, a;
      ht  = b ? 56 : 1040;
      vt  = b ? 32 : 666;
      hv  = b ? 40 : 800;
      vv  = b ? 24 : 600;
      hs0 = hv + (b ? 4 : 56);
      hs1 = hs0 + (b ? 6 : 120) - 1;
      vs0 = vv + (b ? 3 : 37);
      vs1 = vs0 + (b ? 2 : 6) - 1;
      lat = b ? 2 : 1;
      e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_ra = '0; e_rgb = '0;
      t = k - 1;
      if (t >= 0) begin
         h = t % ht;
         v = (t / ht) % vt;
         if (h < hv && v < vv) e_ra = 15'((v / 4) * 200 + h / 4);
      end
      t = k - lat - 1;
      if (t >= 0) begin
         h = t % ht;
         v = (t / ht) % vt;
         e_hs = h >= hs0 && h <= hs1;
         e_vs = v >= vs0 && v <= vs1;
         e_de = h < hv && v < vv;
         a = (v / 4) * 200 + h / 4;
         if (e_de) e_rgb = a[11:0];
         if (CUR_EN && e_de && ((h / 4 == cc && iabs(v / 4 - cr) <= 3) ||
                                (v / 4 == cr && iabs(h / 4 - cc) <= 3))) e_rgb = ~e_rgb;
      end
   endfunction

   task automatic release_a();
      @(negedge clk); rst_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
   endtask

   task automatic release_b();
      @(negedge clk); rst_b = 1'b1;
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests += 4;
      if ({hs_a, vs_a, de_a} !== 3'b000) begin n_fail++; $display("FAIL reset_a_sync got %b exp 000", {hs_a, vs_a, de_a}); end
      if ({ra_a, rgb_a} !== 27'd0) begin n_fail++; $display("FAIL reset_a_data got raddr=%0d rgb=%h exp 0", ra_a, rgb_a); end
      if ({hs_b, vs_b, de_b} !== 3'b000) begin n_fail++; $display("FAIL reset_b_sync got %b exp 000", {hs_b, vs_b, de_b}); end
      if ({ra_b, rgb_b} !== 27'd0) begin n_fail++; $display("FAIL reset_b_data got raddr=%0d rgb=%h exp 0", ra_b, rgb_b); end
   endtask

   task automatic test_line_a();
      logic e_hs, e_vs, e_de;
      logic [14:0] e_ra;
      logic [11:0] e_rgb;
      int rise1 = -1, rise2 = -1, fall1 = -1, de_first = -1, de_last = -1;
      logic hs_prev = 1'b0;
      logic [14:0] ra_h4 = '0, ra_v4 = '0;
      release_a();
      for (int k = 1; k <= 5210; k++) begin
         @(negedge clk);
         model(1'b0, k, 0, 0, e_hs, e_vs, e_de, e_ra, e_rgb);
         n_tests++;
         if ({hs_a, vs_a, de_a, ra_a, rgb_a} !== {e_hs, e_vs, e_de, e_ra, e_rgb}) begin
            n_fail++;
            $display("FAIL line_a k=%0d got hs=%b vs=%b de=%b raddr=%0d rgb=%h exp hs=%b vs=%b de=%b raddr=%0d rgb=%h",
                     k, hs_a, vs_a, de_a, ra_a, rgb_a, e_hs, e_vs, e_de, e_ra, e_rgb);
         end
         if (hs_a && !hs_prev) begin
            if (rise1 < 0) rise1 = k;
            else if (rise2 < 0) rise2 = k;
         end
         if (!hs_a && hs_prev && fall1 < 0) fall1 = k;
         hs_prev = hs_a;
         if (k < 1040 && de_a) begin
            if (de_first < 0) de_first = k;
            de_last = k;
         end
         if (k == 5) ra_h4 = ra_a;
         if (k == 4161) ra_v4 = ra_a;
      end
      n_tests += 7;
      if (rise1 != 858) begin n_fail++; $display("FAIL hs_rise got %0d exp 858", rise1); end
      if (fall1 - rise1 != 120) begin n_fail++; $display("FAIL hs_width got %0d exp 120", fall1 - rise1); end
      if (rise2 - rise1 != 1040) begin n_fail++; $display("FAIL hs_period got %0d exp 1040", rise2 - rise1); end
      if (de_first != 2) begin n_fail++; $display("FAIL de_first got %0d exp 2", de_first); end
      if (de_last != 801) begin n_fail++; $display("FAIL de_last got %0d exp 801", de_last); end
      if (ra_h4 !== 15'd1) begin n_fail++; $display("FAIL raddr_h4 got %0d exp 1", ra_h4); end
      if (ra_v4 !== 15'd200) begin n_fail++; $display("FAIL raddr_v4 got %0d exp 200", ra_v4); end
   endtask

   task automatic test_reset_mid_a();
      logic e_hs, e_vs, e_de;
      logic [14:0] e_ra;
      logic [11:0] e_rgb;
      int rise = -1;
      logic hs_prev = 1'b0;
      repeat ($urandom_range(2000, 4000)) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({hs_a, vs_a, de_a, rgb_a, ra_a} !== 30'd0) begin
         n_fail++;
         $display("FAIL mid_reset_a got hs=%b vs=%b de=%b rgb=%h raddr=%0d exp all 0", hs_a, vs_a, de_a, rgb_a, ra_a);
      end
      rst_a = 1'b0;
      for (int k = 1; k <= 900; k++) begin
         @(negedge clk);
         model(1'b0, k, 0, 0, e_hs, e_vs, e_de, e_ra, e_rgb);
         n_tests++;
         if ({hs_a, vs_a, de_a, ra_a, rgb_a} !== {e_hs, e_vs, e_de, e_ra, e_rgb}) begin
            n_fail++;
            $display("FAIL after_reset_a k=%0d got hs=%b de=%b raddr=%0d rgb=%h exp hs=%b de=%b raddr=%0d rgb=%h",
                     k, hs_a, de_a, ra_a, rgb_a, e_hs, e_de, e_ra, e_rgb);
         end
         if (hs_a && !hs_prev && rise < 0) rise = k;
         hs_prev = hs_a;
      end
      n_tests++;
      if (rise != 858) begin n_fail++; $display("FAIL mid_reset_hs_rise got %0d exp 858", rise); end
   endtask

   task automatic test_frame_b();
      logic e_hs, e_vs, e_de;
      logic [14:0] e_ra;
      logic [11:0] e_rgb;
      int rise1 = -1, rise2 = -1, fall1 = -1, de_blank = 0, t;
      logic vs_prev = 1'b0;
      logic [14:0] max_ra = '0;
      release_b();
      for (int k = 1; k <= 3700; k++) begin
         @(negedge clk);
         model(1'b1, k, 0, 0, e_hs, e_vs, e_de, e_ra, e_rgb);
         n_tests++;
         if ({hs_b, vs_b, de_b, ra_b, rgb_b} !== {e_hs, e_vs, e_de, e_ra, e_rgb}) begin
            n_fail++;
            $display("FAIL frame_b k=%0d got hs=%b vs=%b de=%b raddr=%0d rgb=%h exp hs=%b vs=%b de=%b raddr=%0d rgb=%h",
                     k, hs_b, vs_b, de_b, ra_b, rgb_b, e_hs, e_vs, e_de, e_ra, e_rgb);
         end
         if (vs_b && !vs_prev) begin
            if (rise1 < 0) rise1 = k;
            else if (rise2 < 0) rise2 = k;
         end
         if (!vs_b && vs_prev && fall1 < 0) fall1 = k;
         vs_prev = vs_b;
         t = k - 3;
         if (t >= 0 && (t / 56) % 32 >= 24 && de_b) de_blank++;
         if (ra_b > max_ra) max_ra = ra_b;
      end
      n_tests += 5;
      if (rise1 != 1515) begin n_fail++; $display("FAIL vs_rise got %0d exp 1515", rise1); end
      if (fall1 - rise1 != 112) begin n_fail++; $display("FAIL vs_width got %0d exp 112", fall1 - rise1); end
      if (rise2 - rise1 != 1792) begin n_fail++; $display("FAIL frame_period got %0d exp 1792", rise2 - rise1); end
      if (de_blank != 0) begin n_fail++; $display("FAIL de_in_vblank got %0d exp 0", de_blank); end
      if (max_ra !== 15'd1009) begin n_fail++; $display("FAIL raddr_max got %0d exp 1009", max_ra); end
   endtask

   task automatic test_reset_mid_b();
      logic e_hs, e_vs, e_de;
      logic [14:0] e_ra;
      logic [11:0] e_rgb;
      int stop, rise = -1;
      logic hs_prev = 1'b0;
      stop = 12 * 56 + $urandom_range(0, 55);
      release_b();
      for (int k = 1; k <= stop; k++) begin
         @(negedge clk);
         model(1'b1, k, 0, 0, e_hs, e_vs, e_de, e_ra, e_rgb);
         n_tests++;
         if ({de_b, ra_b, rgb_b} !== {e_de, e_ra, e_rgb}) begin
            n_fail++;
            $display("FAIL pre_reset_b k=%0d got de=%b raddr=%0d rgb=%h exp de=%b raddr=%0d rgb=%h",
                     k, de_b, ra_b, rgb_b, e_de, e_ra, e_rgb);
         end
      end
      rst_b = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({hs_b, vs_b, de_b, rgb_b, ra_b} !== 30'd0) begin
         n_fail++;
         $display("FAIL mid_reset_b got hs=%b vs=%b de=%b rgb=%h raddr=%0d exp all 0", hs_b, vs_b, de_b, rgb_b, ra_b);
      end
      rst_b = 1'b0;
      for (int k = 1; k <= 120; k++) begin
         @(negedge clk);
         model(1'b1, k, 0, 0, e_hs, e_vs, e_de, e_ra, e_rgb);
         n_tests++;
         if ({hs_b, vs_b, de_b, ra_b, rgb_b} !== {e_hs, e_vs, e_de, e_ra, e_rgb}) begin
            n_fail++;
            $display("FAIL after_reset_b k=%0d got hs=%b de=%b raddr=%0d rgb=%h exp hs=%b de=%b raddr=%0d rgb=%h",
                     k, hs_b, de_b, ra_b, rgb_b, e_hs, e_de, e_ra, e_rgb);
         end
         if (hs_b && !hs_prev && rise < 0) rise = k;
         hs_prev = hs_b;
      end
      n_tests++;
      if (rise != 47) begin n_fail++; $display("FAIL mid_reset_b_hs_rise got %0d exp 47", rise); end
   endtask

`ifdef FB_CURSOR_EN
   // Frame 0 shows the reset cursor (0,0); later frames show the cursor decoded before their start
   task automatic test_cursor();
      logic e_hs, e_vs, e_de;
      logic [14:0] e_ra;
      logic [11:0] e_rgb;
      int r0, c0, r1, c1, cc, cr, f, t, inv = 0;
      r0 = $urandom_range(0, 5); c0 = $urandom_range(0, 9);
      r1 = $urandom_range(0, 5); c1 = $urandom_range(0, 9);
      cur_b = 15'(r0 * 200 + c0);
      release_b();
      for (int k = 1; k <= 3 * 1792 + 10; k++) begin
         @(negedge clk);
         t  = k - 3;
         f  = t < 0 ? 0 : t / 1792;
         cc = f == 0 ? 0 : f == 1 ? c0 : c1;
         cr = f == 0 ? 0 : f == 1 ? r0 : r1;
         model(1'b1, k, cc, cr, e_hs, e_vs, e_de, e_ra, e_rgb);
         n_tests++;
         if (rgb_b !== e_rgb) begin
            n_fail++;
            $display("FAIL cursor k=%0d frame=%0d got rgb=%h exp %h (cursor col=%0d row=%0d)", k, f, rgb_b, e_rgb, cc, cr);
         end
         if (de_b && rgb_b !== ra_b[11:0] && rgb_b === ~e_ra[11:0]) inv++;
         if (k == 1792 + 900) cur_b = 15'(r1 * 200 + c1);
      end
      n_tests++;
      if (inv != 0) begin n_fail++; $display("FAIL cursor_sanity got %0d exp 0", inv); end
   endtask
`endif

   initial begin
      cur_a = '0; cur_b = '0; rst_a = 1'b1; rst_b = 1'b1;
      test_reset();
      test_line_a();
      test_reset_mid_a();
      test_frame_b();
      test_reset_mid_b();
`ifdef FB_CURSOR_EN
      test_cursor();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fb_display_unit.md
Name: fb_display_unit

Overview:
- Reader side of the 200x150, 12-bit RGB paint framebuffer.
- Generates 800x600@72 Hz VGA timing from a 50 MHz pixel clock.
- Issues framebuffer read addresses with each stored pixel replicated 4x4 on screen.
- Drives RGB and sync to the VGA pins; optionally overlays a crosshair at the paint cursor.

Parameters:
- H_VIS, 800, visible pixels per line
- H_FP, 56, horizontal front porch (clocks)
- H_SW, 120, hsync width (clocks)
- H_BP, 64, horizontal back porch (clocks); H_TOT = 1040
- V_VIS, 600, visible lines
- V_FP, 37, vertical front porch (lines)
- V_SW, 6, vsync width (lines)
- V_BP, 23, vertical back porch (lines); V_TOT = 666
- FB_W, 200, framebuffer width in pixels; FB_H = 150
- RD_LAT, 1, framebuffer read latency in clocks; valid range 1..2

Ports:
- clk  in  1  pixel clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- cursor  in  15  paint cursor linear address (row*200+col), 0..29999
- raddr  out  15  framebuffer read address
- rdata  in  12  framebuffer read data, valid RD_LAT clocks after raddr
- hs  out  1  hsync, active-high
- vs  out  1  vsync, active-high
- de  out  1  display enable (visible region)
- rgb  out  12  pixel colour {R4,G4,B4}; 0 when de=0

Behaviour:
- Counters: hcnt 0..1039 increments every clk and wraps to 0; vcnt 0..665 increments when hcnt wraps, and wraps to 0 after line 665.
- Stage 0 (counters) produces:
  - vis = (hcnt<800)&&(vcnt<600)
  - hs_i = 856<=hcnt<=975
  - vs_i = 637<=vcnt<=642
- Stage 1 (registered raddr):
  - raddr = (vcnt>>2)*200 + (hcnt>>2) when vis, else 0.
  - Computed with add/shift only (no divider).
  - raddr is 1 clk behind the counters.
- Output alignment:
  - hs, vs and de are the stage-0 signals delayed RD_LAT+1 clks.
  - rgb = rdata registered with matching delay, forced to 0 when delayed de=0.
  - Total latency from counter to pins is RD_LAT+1 clks; with default parameters that is 2.
- Address range: raddr stays within 0..29999 at all times; 29999 is produced at hcnt=799, vcnt=599.
- Reset:
  - hcnt = 0, vcnt = 0, raddr = 0, hs = 0, vs = 0, de = 0, rgb = 0.
  - All delay-pipeline stages are cleared.
  - rst asserted mid-frame takes effect on the next clk edge; the frame restarts at hcnt=0, vcnt=0 after release.
- rdata is ignored while delayed de=0.
- cursor is registered every clk and may change at any time. Its row and column (cursor/200, cursor%200) are derived by a sequential subtract loop of at most 150 clks, restarted on every cursor change. The decoded position is applied only at vcnt=0, hcnt=0, so it is frame-coherent.
- Out-of-range cursor (>29999) is clamped to 29999.

Optional Feature:
- Macro: FB_CURSOR_EN.
- Defined:
  - A framebuffer pixel (col, row) is a cursor pixel when:
    - col==ccol and |row-crow|<=3, or
    - row==crow and |col-ccol|<=3.
  - ccol/crow is the cursor latched at frame start.
  - Cursor pixels output ~rdata; the cross is clipped at the framebuffer edges with no wrap.
  - The cursor test is pipelined to align with rgb; latency is unchanged.
- Undefined: rgb = rdata gated by de; cursor is unused and the decode logic is absent.

Test Plan:
- Release rst, then count clks with default parameters:
  - hs rises at clk 858 and stays high 120 clks.
  - hs period is 1040.
  - de is high for clks 2..801 of each visible line.
- vs timing:
  - vs rises at clk 637*1040+2 and stays high 6240 clks.
  - Frame period is 692640 clks.
  - de is never high on lines 600..665.
- raddr mapping:
  - hcnt=4, vcnt=0 -> raddr=1.
  - hcnt=0, vcnt=4 -> raddr=200.
  - hcnt=799, vcnt=599 -> raddr=29999.
  - Any blanking clk -> raddr=0.
- Data alignment: a RAM model returns rdata = raddr[11:0] after RD_LAT clks. Then rgb at screen pixel (x,y) = ((y>>2)*200+(x>>2))[11:0], and rgb = 0 in blanking. Check with RD_LAT=1 and RD_LAT=2.
- Reset mid-frame: assert rst at vcnt=300 for 1 clk -> next clk has hs=vs=de=0 and rgb=0; the first hs rise follows 858 clks after release.
- FB_CURSOR_EN defined, cursor=15100 (row 75, col 100), rdata=12'h0F0:
  - Screen pixels (400..403, 300..303) show 12'hF0F.
  - Framebuffer col 104 on row 75 shows 12'h0F0.
  - A cursor change mid-frame does not alter the current frame.
